// File: rtl/board_pkg.sv
// Shared board-memory definitions: geometry, piece codes, arbiter client
// select codes and the scan reader state encoding.
package board_pkg;

    localparam int BOARD_ADDR_W = 6;
    localparam int PIECE_W      = 4;
    localparam int NUM_SQUARES  = 64;

    localparam logic [PIECE_W-1:0] PIECE_EMPTY    = 4'd0;
    localparam logic [PIECE_W-1:0] PIECE_W_PAWN   = 4'd1;
    localparam logic [PIECE_W-1:0] PIECE_W_KNIGHT = 4'd2;
    localparam logic [PIECE_W-1:0] PIECE_W_BISHOP = 4'd3;
    localparam logic [PIECE_W-1:0] PIECE_W_ROOK   = 4'd4;
    localparam logic [PIECE_W-1:0] PIECE_W_QUEEN  = 4'd5;
    localparam logic [PIECE_W-1:0] PIECE_W_KING   = 4'd6;
    localparam logic [PIECE_W-1:0] PIECE_B_PAWN   = 4'd9;
    localparam logic [PIECE_W-1:0] PIECE_B_KNIGHT = 4'd10;
    localparam logic [PIECE_W-1:0] PIECE_B_BISHOP = 4'd11;
    localparam logic [PIECE_W-1:0] PIECE_B_ROOK   = 4'd12;
    localparam logic [PIECE_W-1:0] PIECE_B_QUEEN  = 4'd13;
    localparam logic [PIECE_W-1:0] PIECE_B_KING   = 4'd14;

    localparam logic [1:0] SEL_CONTROL   = 2'd0;
    localparam logic [1:0] SEL_VALIDATOR = 2'd1;
    localparam logic [1:0] SEL_DATAPATH  = 2'd2;
    localparam logic [1:0] SEL_VIEW      = 2'd3;

    typedef enum logic [2:0] {
        SCAN_IDLE,
        SCAN_REQ,
        SCAN_WAIT,
        SCAN_OUT,
        SCAN_DONE
    } scan_state_e;

    function automatic logic [BOARD_ADDR_W-1:0] square_addr(
        input logic [2:0] x,
        input logic [2:0] y
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/board_read_port.sv
// Grant-and-latency handshake for one arbitrated client of the board RAM.
// The owner raises go while requesting and hold while the read is in flight.
module board_read_port
    import board_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic                    hold,
    input  logic [BOARD_ADDR_W-1:0] addr,
    input  logic                    mem_grant,
    input  logic [PIECE_W-1:0]      mem_data,
    output logic [BOARD_ADDR_W-1:0] mem_address,
    output logic                    issue,
    output logic [PIECE_W-1:0]      data,
    output logic                    data_valid,
    output logic                    retry
);

    localparam int LAT_W = $clog2(READ_LATENCY + 1);

    logic [LAT_W-1:0] lat_q, lat_d;

    always_comb begin
        mem_address = addr;
        data        = mem_data;
        issue       = go & mem_grant;
        retry       = hold & ~mem_grant;
        // Data is only trusted if the port stayed ours for the whole read.
        data_valid  = hold & mem_grant & (lat_q == LAT_W'(1));
        lat_d       = lat_q;
        if (issue) begin
            lat_d = LAT_W'(READ_LATENCY);
        end else if (hold && mem_grant && lat_q != '0) begin
            lat_d = lat_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_q <= '0;
        end else begin
            lat_q <= lat_d;
        end
    end

endmodule

// File: rtl/board_scan_reader.sv
// View client of the board RAM: sweeps all squares in order and streams
// (x, y, piece) records to the renderer under valid/ready backpressure.
module board_scan_reader
    import board_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_req,
    input  logic                    mem_grant,
    output logic [BOARD_ADDR_W-1:0] mem_address,
    input  logic [PIECE_W-1:0]      mem_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_x,
    output logic [2:0]              out_y,
    output logic [PIECE_W-1:0]      out_piece
);

    scan_state_e             state_q, state_d;
    logic [BOARD_ADDR_W-1:0] cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    req_q, req_d;
    logic                    valid_q, valid_d;
    logic [2:0]              x_q, x_d;
    logic [2:0]              y_q, y_d;
    logic [PIECE_W-1:0]      piece_q, piece_d;

    logic               rd_go, rd_hold;
    logic               rd_issue, rd_valid, rd_retry;
    logic [PIECE_W-1:0] rd_data;

    assign rd_go   = (state_q == SCAN_REQ);
    assign rd_hold = (state_q == SCAN_WAIT);

    board_read_port #(
        .READ_LATENCY(READ_LATENCY)
    ) u_port (
        .clk        (clk),
        .reset      (reset),
        .go         (rd_go),
        .hold       (rd_hold),
        .addr       (cnt_q),
        .mem_grant  (mem_grant),
        .mem_data   (mem_data),
        .mem_address(mem_address),
        .issue      (rd_issue),
        .data       (rd_data),
        .data_valid (rd_valid),
        .retry      (rd_retry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        piece_d = piece_q;
        if (abort && state_q != SCAN_IDLE) begin
            state_d = SCAN_IDLE;
            busy_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            unique case (state_q)
                SCAN_IDLE: begin
                    if (start && !abort) begin
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = SCAN_REQ;
                    end
                end
                SCAN_REQ: begin
                    if (rd_issue) state_d = SCAN_WAIT;
                end
                SCAN_WAIT: begin
                    if (rd_retry) begin
                        state_d = SCAN_REQ;
                    end else if (rd_valid) begin
                        piece_d = rd_data;
                        x_d     = cnt_q[2:0];
                        y_d     = cnt_q[5:3];
                        valid_d = 1'b1;
                        state_d = SCAN_OUT;
                    end
                end
                SCAN_OUT: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        if (cnt_q == BOARD_ADDR_W'(NUM_SQUARES - 1)) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = SCAN_DONE;
                        end else begin
                            cnt_d   = cnt_q + BOARD_ADDR_W'(1);
                            state_d = SCAN_REQ;
                        end
                    end
                end
                SCAN_DONE: state_d = SCAN_IDLE;
                default:   state_d = SCAN_IDLE;
            endcase
        end
        // The port is released while the consumer stalls in OUT.
        req_d = (state_d == SCAN_REQ) || (state_d == SCAN_WAIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            piece_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            piece_q <= piece_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = req_q;
    assign out_valid = valid_q;
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_piece = piece_q;

endmodule

// File: tb/tb_board_scan_reader.sv
// Self-checking bench for board_scan_reader: RAM and arbiter models plus a
// scoreboard of expected records popped on each output handshake.
module tb_board_scan_reader;

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        logic [3:0] p;
    } rec_t;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic       mem_req;
    logic       mem_grant;
    logic [5:0] mem_address;
    logic [3:0] mem_data;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_x;
    logic [2:0] out_y;
    logic [3:0] out_piece;

    logic [3:0] mem [64];
    logic [3:0] rd_q;
    rec_t       exp_q [$];
    logic [9:0] got [64];
    int         checks;
    int         failures;
    int         rec_count;
    int         done_count;

    board_scan_reader #(
        .READ_LATENCY(1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .mem_req    (mem_req),
        .mem_grant  (mem_grant),
        .mem_address(mem_address),
        .mem_data   (mem_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_piece  (out_piece)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rd_q <= mem[mem_address];
    assign mem_data = rd_q;

    always @(negedge clk) begin
        if (!reset && done) done_count++;
        if (!reset && out_valid && out_ready) begin
            rec_t e;
            if (rec_count < 64) got[rec_count] = {out_x, out_y, out_piece};
            rec_count++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_record got x=%0d y=%0d p=%0d",
                         out_x, out_y, out_piece);
            end else begin
                e = exp_q.pop_front();
                if ({out_x, out_y, out_piece} !== {e.x, e.y, e.p}) begin
                    failures++;
                    $display("FAIL record got x=%0d y=%0d p=%0d want x=%0d y=%0d p=%0d",
                             out_x, out_y, out_piece, e.x, e.y, e.p);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [3:0] k);
        for (int i = 0; i < 64; i++) begin
            logic [5:0] a;
            a = 6'(i);
            mem[i] = a[3:0] ^ k;
        end
    endtask

    task automatic begin_sweep();
        exp_q.delete();
        rec_count  = 0;
        done_count = 0;
        for (int i = 0; i < 64; i++) begin
            rec_t r;
            logic [5:0] a;
            a = 6'(i);
            r.x = a[2:0];
            r.y = a[5:3];
            r.p = mem[i];
            exp_q.push_back(r);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output bit ok);
        cyc = 0;
        while (!done && cyc < 2000) begin
            tick();
            cyc++;
        end
        ok = done;
    endtask

    task automatic finish_sweep(input string name);
        int cyc;
        bit ok;
        wait_done(cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_done_timeout got done=0 want done=1", name);
        end
        tick();
        checks++;
        if (rec_count != 64 || exp_q.size() != 0 || done_count != 1) begin
            failures++;
            $display("FAIL %s_complete got recs=%0d left=%0d dones=%0d want 64 0 1",
                     name, rec_count, exp_q.size(), done_count);
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL %s_after got busy=%b done=%b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({busy, done, mem_req, mem_address, out_valid, out_x, out_y, out_piece}
            !== 20'd0) begin
            failures++;
            $display("FAIL reset_values got busy=%b done=%b req=%b addr=%0d v=%b want all 0",
                     busy, done, mem_req, mem_address, out_valid);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_full_sweep();
        int cyc;
        bit ok;
        fill(4'h0);
        mem_grant = 1'b1;
        out_ready = 1'b1;
        begin_sweep();
        pulse_start();
        checks++;
        if ({busy, mem_req} !== 2'b11) begin
            failures++;
            $display("FAIL sweep_busy got busy=%b req=%b want 1 1", busy, mem_req);
        end
        wait_done(cyc, ok);
        checks++;
        if (!ok || cyc < 191 || cyc > 193) begin
            failures++;
            $display("FAIL sweep_latency got %0d cycles done=%b want 192", cyc, done);
        end
        tick();
        checks++;
        if (got[37] !== {3'd5, 3'd4, 4'd5}) begin
            failures++;
            $display("FAIL square37 got %h want %h", got[37], {3'd5, 3'd4, 4'd5});
        end
        checks++;
        if (rec_count != 64 || exp_q.size() != 0 || done_count != 1) begin
            failures++;
            $display("FAIL sweep_complete got recs=%0d left=%0d dones=%0d want 64 0 1",
                     rec_count, exp_q.size(), done_count);
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            failures++;
            $display("FAIL sweep_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_grant_stall();
        int n;
        fill(4'h3);
        mem_grant = 1'b1;
        out_ready = 1'b1;
        begin_sweep();
        pulse_start();
        n = 0;
        while (!(out_valid && out_x == 3'd1 && out_y == 3'd1) && n < 200) begin
            tick();
            n++;
        end
        mem_grant = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if ({mem_req, mem_address, out_valid} !== {1'b1, 6'd10, 1'b0}) begin
                failures++;
                $display("FAIL grant_hold%0d got req=%b addr=%0d v=%b want 1 10 0",
                         i, mem_req, mem_address, out_valid);
            end
            if (i == 5) mem_grant = 1'b1;
            tick();
        end
        mem_grant = 1'b0;
        checks++;
        if ({mem_req, mem_address, out_valid} !== {1'b1, 6'd10, 1'b0}) begin
            failures++;
            $display("FAIL grant_wait got req=%b addr=%0d v=%b want 1 10 0",
                     mem_req, mem_address, out_valid);
        end
        tick();
        mem_grant = 1'b1;
        checks++;
        if ({mem_req, mem_address, out_valid} !== {1'b1, 6'd10, 1'b0}) begin
            failures++;
            $display("FAIL grant_retry got req=%b addr=%0d v=%b want 1 10 0",
                     mem_req, mem_address, out_valid);
        end
        tick();
        tick();
        checks++;
        if ({out_valid, out_x, out_y, out_piece} !== {1'b1, 3'd2, 3'd1, 4'd9}) begin
            failures++;
            $display("FAIL grant_reread got v=%b x=%0d y=%0d p=%0d want 1 2 1 9",
                     out_valid, out_x, out_y, out_piece);
        end
        finish_sweep("grant");
    endtask

    task automatic test_ready_stall();
        int n;
        fill(4'h7);
        mem_grant = 1'b1;
        out_ready = 1'b0;
        begin_sweep();
        pulse_start();
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({out_valid, out_x, out_y, out_piece, mem_req}
                !== {1'b1, 3'd0, 3'd0, 4'd7, 1'b0}) begin
                failures++;
                $display("FAIL stall%0d got v=%b x=%0d y=%0d p=%0d req=%b want 1 0 0 7 0",
                         i, out_valid, out_x, out_y, out_piece, mem_req);
            end
            if (i == 7) out_ready = 1'b1;
            tick();
        end
        checks++;
        if ({mem_req, mem_address, out_valid} !== {1'b1, 6'd1, 1'b0}) begin
            failures++;
            $display("FAIL stall_next got req=%b addr=%0d v=%b want 1 1 0",
                     mem_req, mem_address, out_valid);
        end
        finish_sweep("stall");
    endtask

    task automatic test_abort();
        int n;
        fill(4'h5);
        mem_grant = 1'b1;
        out_ready = 1'b1;
        begin_sweep();
        pulse_start();
        n = 0;
        while (!(mem_req && mem_address == 6'd20) && n < 200) begin
            tick();
            n++;
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if ({busy, mem_req, out_valid} !== 3'b000) begin
            failures++;
            $display("FAIL abort_idle got busy=%b req=%b v=%b want 0 0 0",
                     busy, mem_req, out_valid);
        end
        checks++;
        if (exp_q.size() != 44) begin
            failures++;
            $display("FAIL abort_records got left=%0d want 44", exp_q.size());
        end
        repeat (5) tick();
        checks++;
        if (done_count != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got dones=%0d busy=%b want 0 0", done_count, busy);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checks++;
        if ({busy, mem_req} !== 2'b00) begin
            failures++;
            $display("FAIL start_abort got busy=%b req=%b want 0 0", busy, mem_req);
        end
        begin_sweep();
        pulse_start();
        checks++;
        if ({mem_req, mem_address} !== {1'b1, 6'd0}) begin
            failures++;
            $display("FAIL abort_restart got req=%b addr=%0d want 1 0", mem_req, mem_address);
        end
        finish_sweep("abort");
    endtask

    task automatic test_start_ignored();
        int n;
        fill(4'hC);
        begin_sweep();
        pulse_start();
        n = 0;
        while (mem_address != 6'd30 && n < 200) begin
            tick();
            n++;
        end
        pulse_start();
        finish_sweep("restart");
    endtask

    task automatic test_reset_mid();
        int n;
        fill(4'h9);
        begin_sweep();
        pulse_start();
        n = 0;
        while (!(out_valid && out_x == 3'd2 && out_y == 3'd6) && n < 300) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({busy, done, mem_req, mem_address, out_valid, out_x, out_y, out_piece}
            !== 20'd0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b req=%b addr=%0d v=%b want all 0",
                     busy, mem_req, mem_address, out_valid);
        end
        reset = 1'b0;
        exp_q.delete();
        rec_count = 0;
        repeat (10) tick();
        checks++;
        if (rec_count != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_quiet got recs=%0d v=%b want 0 0", rec_count, out_valid);
        end
        begin_sweep();
        pulse_start();
        finish_sweep("post_reset");
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rec_count  = 0;
        done_count = 0;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        mem_grant  = 1'b1;
        out_ready  = 1'b1;
        fill(4'h0);
        test_reset();
        test_full_sweep();
        test_grant_stall();
        test_ready_stall();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/board_scan_reader.md
Name: board_scan_reader

Overview:
- Read-side client of the shared 64-square board memory: sweeps squares 0..63 in order through the arbitrated board port and streams (x, y, piece) records to a downstream consumer, e.g. the square renderer.
- Owns the board-port request/grant handshake.
- Owns the board RAM's synchronous read latency.
- Applies valid/ready backpressure towards the consumer.
- Sits between the board memory arbiter (as the view client) and the drawing logic.

Parameters:
- READ_LATENCY, 1, cycles from address presented to board data valid (synchronous RAM read).
- NUM_SQUARES, 64, squares per sweep; address width fixed at 6.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse: begin a sweep (ignored unless idle)
- abort  input  1  level: cancel current sweep, return to idle
- busy  output  1  high from accepted start until done/abort
- done  output  1  one-cycle pulse after square 63 is accepted downstream
- mem_req  output  1  request ownership of the board port
- mem_grant  input  1  arbiter grants board port this cycle (arbiter drives select=view)
- mem_address  output  6  board address, {y[2:0], x[2:0]}
- mem_data  input  4  board read data (piece code)
- out_valid  output  1  record valid
- out_ready  input  1  consumer accepts record
- out_x  output  3  column of record
- out_y  output  3  row of record
- out_piece  output  4  piece code of record

Behaviour:
- Reset values: busy=0, done=0, mem_req=0, mem_address=0, out_valid=0, out_x=0, out_y=0, out_piece=0, state=IDLE, square counter=0.
- Reset mid-sweep has the same effect; no record is emitted afterward.
- IDLE:
  - start=1 clears the counter to 0, sets busy=1 and goes to REQ.
  - start while not IDLE is ignored.
- REQ:
  - mem_req=1 and mem_address=counter.
  - When mem_grant=1, go to WAIT and load the latency counter with READ_LATENCY.
- WAIT:
  - mem_req=1 and mem_address is held stable.
  - Decrement the latency counter each cycle; when it reaches 0, capture mem_data into out_piece.
  - Set out_x = counter[2:0], out_y = counter[5:3], out_valid=1, go to OUT.
  - If mem_grant drops during WAIT, discard the read and return to REQ with the same counter.
  - No partial or stale data is ever emitted.
- OUT:
  - mem_req=0, which releases the port while waiting on the consumer.
  - out_valid and all out_* fields are held stable until out_ready=1.
  - On the handshake (out_valid and out_ready): if counter==NUM_SQUARES-1, go to DONE; else increment the counter and go to REQ.
  - out_valid drops the cycle after the handshake.
- DONE: done=1 for exactly one cycle, busy=0, back to IDLE. The counter wraps back to 0 only via the next start.
- Minimum throughput: 1 (REQ with grant) + READ_LATENCY + 1 (OUT with ready) cycles per square, i.e. 3 cycles at defaults, 192 cycles per sweep.
- abort=1 in any non-IDLE state:
  - Next cycle: IDLE, mem_req=0, out_valid=0, busy=0, and no done pulse.
  - abort has priority over a simultaneous handshake or grant.
- start and abort in the same IDLE cycle: abort wins and the block stays idle.
- mem_address is driven only from the counter; it holds its last value while idle and is never X.
- mem_grant is ignored outside REQ/WAIT.

Decomposition:
- Shared package (board_pkg):
  - BOARD_ADDR_W=6, PIECE_W=4, NUM_SQUARES=64.
  - Piece code constants (EMPTY=4'd0, etc.) shared with the datapath, validator and control.
  - Arbiter client select codes: CONTROL=2'd0, VALIDATOR=2'd1, DATAPATH=2'd2, VIEW=2'd3.
  - The state enumeration for this block.
- One sub-module is natural: board_read_port. It covers the REQ/WAIT grant-and-latency handshake, with inputs addr and go and outputs data and data_valid/retry. It is reusable by the validator and control clients.
- The sweep counter, output register and FSM stay in the top.

Test Plan:
- Grant always 1, ready always 1, board filled with piece = addr[3:0] -> 64 records in order x=0..7 per row y=0..7; square 37 gives x=5, y=4, piece=4'd5; done pulses once at cycle 192±1 after start; busy low afterward.
- Grant withheld 5 cycles on square 10, then dropped for 1 cycle mid-WAIT -> no record emitted for the aborted read; square 10 re-read; correct piece; mem_address=10 held throughout.
- out_ready held 0 for 8 cycles on square 0 -> out_valid, out_x=0, out_y=0 and out_piece stable for all 8 cycles; mem_req=0 during the stall; square 1 requested the cycle after ready.
- abort asserted while in WAIT on square 20 -> IDLE next cycle; mem_req=0, out_valid=0, no done; then start -> sweep restarts at square 0.
- start pulsed again mid-sweep at square 30 -> ignored; sweep completes with exactly 64 records.
- Synchronous reset asserted while out_valid=1 on square 50 -> next cycle all outputs at reset values; no further records; a subsequent start yields a full sweep.
